// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage between ID and MEM.
//   Single-cycle ALU (ADD/SUB/logic/shifts/compares), a multi-cycle
//   multiply, and branch/jump redirect resolution, with a valid/ready
//   handshake on both sides and an output register that holds under
//   backpressure.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid / in_ready        operation handshake from ID
//   rs1_data, rs2_data, imm, pc operands, immediate, instruction PC
//   alu_op, alu_src            operation select, operand-B select (1 = imm)
//   branch, jump, jump_reg     control-transfer kind
//   flush                      discard held / in-flight operation
//   out_valid / out_ready      result handshake toward MEM
//   alu_result, rs2_fwd, pc_target, branch_taken  registered results
//   busy                       multiply in progress
module ex_stage_pipe #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [3:0]      alu_op,
   input  logic            alu_src,
   input  logic            branch,
   input  logic            jump,
   input  logic            jump_reg,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] rs2_fwd,
   output logic [XLEN-1:0] pc_target,
   output logic            branch_taken,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] FOUR     = XLEN'(4);
   localparam logic [3:0]      CNT_INIT = 4'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,  OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
      OP_XOR  = 4'd4,  OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
      OP_SLT  = 4'd8,  OP_SLTU = 4'd9, OP_MUL = 4'd10
   } alu_op_e;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              busy_q, out_valid_q, branch_taken_q;
   logic [XLEN-1:0]   alu_result_q, rs2_fwd_q, pc_target_q;
   // Operands and redirect candidates parked for the multiply
   logic [XLEN-1:0]   mul_a_q, mul_b_q, tgt_q, link_q;
   logic              jmp_q, br_q;

   logic [XLEN-1:0]   opb, alu_d, link_d, jr_sum, taken_tgt_d, tgt_d, result_d, prod;
   logic [SHW-1:0]    shamt;
   logic              taken_d, mul_taken, accept;

   assign opb    = alu_src ? imm : rs2_data;
   assign shamt  = opb[SHW-1:0];

   // Multiply is not produced here; it has its own registered path.
   always_comb begin
      alu_d = '0;
      case (alu_op)
         OP_ADD:  alu_d = rs1_data + opb;
         OP_SUB:  alu_d = rs1_data - opb;
         OP_AND:  alu_d = rs1_data & opb;
         OP_OR:   alu_d = rs1_data | opb;
         OP_XOR:  alu_d = rs1_data ^ opb;
         OP_SLL:  alu_d = rs1_data << shamt;
         OP_SRL:  alu_d = rs1_data >> shamt;
         OP_SRA:  alu_d = $signed(rs1_data) >>> shamt;
         OP_SLT:  alu_d = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(opb)};
         OP_SLTU: alu_d = {{(XLEN-1){1'b0}}, rs1_data < opb};
         default: alu_d = '0;
      endcase
   end

   assign link_d      = pc + FOUR;
   assign jr_sum      = rs1_data + imm;
   assign taken_tgt_d = jump_reg ? {jr_sum[XLEN-1:1], 1'b0} : (pc + imm);
   assign taken_d     = jump_reg | jump | (branch && (alu_d == '0));
   assign tgt_d       = taken_d ? taken_tgt_d : link_d;
   assign result_d    = (jump | jump_reg) ? link_d : alu_d;

   // Multiply completion: branch condition evaluated on the product
   assign prod      = mul_a_q * mul_b_q;
   assign mul_taken = jmp_q | (br_q && (prod == '0));

   assign in_ready = !busy_q && (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         busy_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         branch_taken_q <= 1'b0;
         alu_result_q   <= '0;
         rs2_fwd_q      <= '0;
         pc_target_q    <= '0;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         tgt_q          <= '0;
         link_q         <= '0;
         jmp_q          <= 1'b0;
         br_q           <= 1'b0;
      end else if (flush) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         busy_q         <= 1'b0;
         out_valid_q    <= 1'b0;
         branch_taken_q <= 1'b0;
      end else if (accept) begin
         rs2_fwd_q <= rs2_data;
         if (alu_op == OP_MUL) begin
            state_q        <= MUL;
            cnt_q          <= CNT_INIT;
            busy_q         <= 1'b1;
            out_valid_q    <= 1'b0;
            branch_taken_q <= 1'b0;
            mul_a_q        <= rs1_data;
            mul_b_q        <= opb;
            tgt_q          <= taken_tgt_d;
            link_q         <= link_d;
            jmp_q          <= jump | jump_reg;
            br_q           <= branch;
         end else begin
            state_q        <= HOLD;
            out_valid_q    <= 1'b1;
            alu_result_q   <= result_d;
            pc_target_q    <= tgt_d;
            branch_taken_q <= taken_d;
         end
      end else begin
         case (state_q)
            MUL: begin
               if (cnt_q == 4'd0) begin
                  state_q        <= HOLD;
                  busy_q         <= 1'b0;
                  out_valid_q    <= 1'b1;
                  alu_result_q   <= jmp_q ? link_q : prod;
                  pc_target_q    <= mul_taken ? tgt_q : link_q;
                  branch_taken_q <= mul_taken;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state_q        <= IDLE;
                  out_valid_q    <= 1'b0;
                  branch_taken_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy         = busy_q;
   assign out_valid    = out_valid_q;
   assign alu_result   = alu_result_q;
   assign rs2_fwd      = rs2_fwd_q;
   assign pc_target    = pc_target_q;
   assign branch_taken = branch_taken_q;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: directed and randomized checks of ex_stage_pipe against
// a transaction-level reference model.
module tb_ex_stage_pipe;

   localparam int XLEN = 32;
   localparam int MC   = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid, in_ready;
   logic [XLEN-1:0] rs1_data, rs2_data, imm, pc;
   logic [3:0]      alu_op;
   logic            alu_src, branch, jump, jump_reg, flush;
   logic            out_valid, out_ready;
   logic [XLEN-1:0] alu_result, rs2_fwd, pc_target;
   logic            branch_taken, busy;

   always #5 clk = ~clk;

   ex_stage_pipe #(.XLEN(XLEN), .MUL_CYCLES(MC)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
      .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .jump(jump),
      .jump_reg(jump_reg), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .alu_result(alu_result), .rs2_fwd(rs2_fwd),
      .pc_target(pc_target), .branch_taken(branch_taken), .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [XLEN-1:0] res;
      logic [XLEN-1:0] rs2;
      logic [XLEN-1:0] tgt;
      logic            taken;
   } txn_t;

   // Everything an operation will eventually show, computed straight from
   // the operation's definition; the pipeline only decides when it appears.
   function automatic txn_t golden(input logic [3:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] r2, input logic [XLEN-1:0] im,
                                   input logic [XLEN-1:0] p, input logic src,
                                   input logic br, input logic j, input logic jr);
      txn_t t;
      logic [XLEN-1:0] b, alu, link, s;
      b = src ? im : r2;
      case (op)
         4'd0:    alu = a + b;
         4'd1:    alu = a - b;
         4'd2:    alu = a & b;
         4'd3:    alu = a | b;
         4'd4:    alu = a ^ b;
         4'd5:    alu = a << (b % XLEN);
         4'd6:    alu = a >> (b % XLEN);
         4'd7:    alu = $signed(a) >>> (b % XLEN);
         4'd8:    alu = ($signed(a) < $signed(b)) ? XLEN'(1) : XLEN'(0);
         4'd9:    alu = (a < b) ? XLEN'(1) : XLEN'(0);
         4'd10:   alu = a * b;
         default: alu = '0;
      endcase
      link  = p + XLEN'(4);
      t.rs2 = r2;
      t.res = (j || jr) ? link : alu;
      if (jr) begin
         s       = a + im;
         s[0]    = 1'b0;
         t.tgt   = s;
         t.taken = 1'b1;
      end else if (j || (br && alu == '0)) begin
         t.tgt   = p + im;
         t.taken = 1'b1;
      end else begin
         t.tgt   = link;
         t.taken = 1'b0;
      end
      return t;
   endfunction

   logic m_valid, m_busy;
   int   m_left;
   txn_t m_out, m_pend;

   function automatic logic m_ready();
      return !m_busy && (!m_valid || out_ready) && !flush;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
         m_left  <= 0;
      end else if (flush) begin
         m_valid <= 1'b0;
         m_busy  <= 1'b0;
      end else if (in_valid && m_ready()) begin
         if (alu_op == 4'd10) begin
            m_busy  <= 1'b1;
            m_valid <= 1'b0;
            m_left  <= MC;
            m_pend  <= golden(alu_op, rs1_data, rs2_data, imm, pc, alu_src, branch, jump, jump_reg);
         end else begin
            m_valid <= 1'b1;
            m_out   <= golden(alu_op, rs1_data, rs2_data, imm, pc, alu_src, branch, jump, jump_reg);
         end
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b1;
            m_out   <= m_pend;
         end
      end else if (m_valid && out_ready) begin
         m_valid <= 1'b0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         chkb("rst out_valid", out_valid, 1'b0);
         chkb("rst busy", busy, 1'b0);
         chkb("rst branch_taken", branch_taken, 1'b0);
         chk("rst alu_result", alu_result, '0);
         chk("rst rs2_fwd", rs2_fwd, '0);
         chk("rst pc_target", pc_target, '0);
      end else begin
         chkb("out_valid", out_valid, m_valid);
         chkb("busy", busy, m_busy);
         chkb("in_ready", in_ready, !m_busy && (!m_valid || out_ready) && !flush);
         if (m_valid) begin
            chk("alu_result", alu_result, m_out.res);
            chk("rs2_fwd", rs2_fwd, m_out.rs2);
            chk("pc_target", pc_target, m_out.tgt);
            chkb("branch_taken", branch_taken, m_out.taken);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] r2,
                         input logic [XLEN-1:0] im, input logic [XLEN-1:0] p, input logic src,
                         input logic br, input logic j, input logic jr);
      alu_op = op; rs1_data = a; rs2_data = r2; imm = im; pc = p;
      alu_src = src; branch = br; jump = j; jump_reg = jr;
   endtask

   task automatic quiet();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      branch = 1'b0; jump = 1'b0; jump_reg = 1'b0;
   endtask

   logic [XLEN-1:0] ra, rb;

   initial begin
      quiet();
      set_op(4'd0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      step();
      rst_n = 1'b1;

      // ADD 5+7
      set_op(4'd0, 32'd5, 32'd7, 32'd0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      @(negedge clk);
      chkb("add valid", out_valid, 1'b1);
      chk("add result", alu_result, 32'd12);
      chkb("add taken", branch_taken, 1'b0);
      chk("add target", pc_target, 32'h44);
      chk("model add result", m_out.res, 32'd12);

      // MUL 3 * 0xFFFFFFFF
      step();
      set_op(4'd10, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      for (int i = 0; i < MC; i++) begin
         @(negedge clk);
         chkb("mul busy", busy, 1'b1);
         chkb("mul in_ready", in_ready, 1'b0);
         chkb("mul no valid", out_valid, 1'b0);
      end
      @(negedge clk);
      chkb("mul valid", out_valid, 1'b1);
      chkb("mul busy done", busy, 1'b0);
      chk("mul result", alu_result, 32'hFFFF_FFFD);
      chk("model mul result", m_out.res, 32'hFFFF_FFFD);

      // jump_reg
      step();
      set_op(4'd0, 32'h1001, 32'd0, 32'd4, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1);
      in_valid = 1'b1; step(); quiet();
      @(negedge clk);
      chk("jr target", pc_target, 32'h1004);
      chk("jr link", alu_result, 32'h104);
      chkb("jr taken", branch_taken, 1'b1);
      chk("model jr target", m_out.tgt, 32'h1004);

      // branch SUB equal / not equal
      step();
      set_op(4'd1, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      @(negedge clk);
      chk("beq target", pc_target, 32'h1F8);
      chkb("beq taken", branch_taken, 1'b1);
      step();
      set_op(4'd1, 32'd9, 32'd8, 32'hFFFF_FFF8, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      @(negedge clk);
      chk("bne target", pc_target, 32'h204);
      chkb("bne taken", branch_taken, 1'b0);
      chk("model bne target", m_out.tgt, 32'h204);

      // backpressure, then accept with out_ready in the same cycle
      step();
      set_op(4'd0, 32'd100, 32'd23, 32'd0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; out_ready = 1'b0; step();
      set_op(4'd4, 32'hF0, 32'h0F, 32'd0, 32'h304, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chkb("bp valid", out_valid, 1'b1);
         chk("bp result", alu_result, 32'd123);
         chk("bp rs2_fwd", rs2_fwd, 32'd23);
         chk("bp target", pc_target, 32'h304);
         chkb("bp in_ready", in_ready, 1'b0);
         step();
      end
      out_ready = 1'b1; step(); quiet();
      @(negedge clk);
      chkb("bp accept valid", out_valid, 1'b1);
      chk("bp accept result", alu_result, 32'hFF);

      // flush in second MUL cycle
      step();
      set_op(4'd10, 32'd6, 32'd7, 32'd0, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      step();
      flush = 1'b1; step(); flush = 1'b0;
      @(negedge clk);
      chkb("flush busy", busy, 1'b0);
      chkb("flush valid", out_valid, 1'b0);
      for (int i = 0; i < MC + 2; i++) begin
         step();
         @(negedge clk);
         chkb("flush no result", out_valid, 1'b0);
      end
      step();
      set_op(4'd0, 32'd1, 32'd2, 32'd0, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      @(negedge clk);
      chkb("post-flush valid", out_valid, 1'b1);
      chk("post-flush result", alu_result, 32'd3);

      // reset pulse mid-MUL
      step();
      set_op(4'd10, 32'd5, 32'd5, 32'd0, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      step();
      rst_n = 1'b0;
      #2;
      chkb("async rst busy", busy, 1'b0);
      chkb("async rst valid", out_valid, 1'b0);
      chk("async rst result", alu_result, 32'd0);
      step();
      rst_n = 1'b1;
      set_op(4'd0, 32'd40, 32'd2, 32'd0, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1; step(); quiet();
      @(negedge clk);
      chkb("post-rst valid", out_valid, 1'b1);
      chk("post-rst result", alu_result, 32'd42);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step();
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         if ($urandom_range(0, 3) == 0) ra = ra & 32'hFF;
         set_op(($urandom_range(0, 4) == 0) ? 4'd10 : 4'($urandom_range(0, 15)),
                ra, rb, $urandom, $urandom & 32'hFFFF_FFFC,
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
      end
      step(); quiet();
      repeat (MC + 3) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ex_stage_pipe.md
EX_STAGE_PIPE -- requirements
Module: ex_stage_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (legal values 32 and 64).
REQ-002 SHALL have parameter MUL_CYCLES, default 4, multiply latency in cycles (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port in_valid  input  1  ID presents an operation.
REQ-006 SHALL have port in_ready  output  1  block accepts the operation this cycle.
REQ-007 SHALL have ports rs1_data, rs2_data, imm, pc  input  XLEN each  operands, immediate and instruction PC.
REQ-008 SHALL have port alu_op  input  4  operation select.
REQ-009 SHALL have ports alu_src, branch, jump, jump_reg  input  1 each  operand-B select and control-transfer kind.
REQ-010 SHALL have port flush  input  1  discard any held or in-flight operation.
REQ-011 SHALL have ports out_valid  output  1  and out_ready  input  1  for the handshake toward MEM.
REQ-012 SHALL have ports alu_result, rs2_fwd, pc_target  output  XLEN each  registered results.
REQ-013 SHALL have port branch_taken  output  1  registered redirect request.
REQ-014 SHALL have port busy  output  1  multiply in progress.

Function
REQ-015 SHALL define operand B as imm when alu_src=1, and as rs2_data otherwise.
REQ-016 SHALL use alu_op encoding 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low XLEN bits); codes 11-15 SHALL produce result 0.
REQ-017 SHALL use only the low log2(XLEN) bits of operand B as the shift amount; all sums SHALL wrap modulo 2^XLEN.
REQ-018 SHALL drive in_ready = !busy && (!out_valid || out_ready) && !flush.
REQ-019 SHALL accept an operation only when in_valid && in_ready are both high at a rising edge.
REQ-020 SHALL, for a non-MUL operation accepted at edge N, present its result with out_valid=1 after edge N (one-cycle latency).
REQ-021 SHALL implement the FSM states IDLE, MUL and HOLD.
REQ-022 SHALL, in IDLE, go from IDLE to MUL on acceptance of alu_op=10, with busy=1 and a cycle counter loaded with MUL_CYCLES-1.
REQ-023 SHALL, in MUL, decrement the counter each cycle; at count 0 it SHALL register the product, set out_valid=1, clear busy and enter HOLD.
REQ-024 SHALL give a MUL accepted at edge N an out_valid that first goes high after edge N+MUL_CYCLES.
REQ-025 SHALL leave HOLD for IDLE when out_valid && out_ready and no new operation is accepted; back-to-back acceptance in the same cycle SHALL be allowed.
REQ-026 SHALL hold all registered outputs stable while out_valid=1 and out_ready=0.
REQ-027 SHALL compute the redirect fields at acceptance, with priority jump_reg > jump > branch:
- jump_reg: pc_target = (rs1_data+imm) with bit 0 cleared, branch_taken=1.
- jump: pc_target = pc+imm, branch_taken=1.
- branch and ALU result == 0: pc_target = pc+imm, branch_taken=1.
- otherwise: pc_target = pc+4, branch_taken=0.
REQ-028 SHALL drive alu_result = pc+4 for jump and jump_reg (link value).
REQ-029 SHALL set rs2_fwd to the rs2_data captured at acceptance.
REQ-030 SHALL, when flush is high at an edge, clear out_valid and branch_taken, abort any MUL, clear busy and enter IDLE; flush SHALL win over simultaneous acceptance and out_ready.
REQ-031 SHALL make branch_taken meaningful only while out_valid=1 and SHALL assert it for exactly one accepted transfer.

Reset
REQ-032 SHALL, while rst_n=0, immediately force the FSM to IDLE, out_valid=0, busy=0, branch_taken=0, and alu_result, rs2_fwd and pc_target to 0, independent of clk.
REQ-033 SHALL, on deassertion of rst_n mid-MUL, leave no result produced and SHALL accept a new operation on the first clock after deassertion.

Verification
REQ-034 SHALL be tested with ADD: rs1=5, rs2=7, alu_src=0, out_ready=1 -> next cycle out_valid=1, alu_result=12, branch_taken=0, pc_target=pc+4.
REQ-035 SHALL be tested with MUL, MUL_CYCLES=4: rs1=3, rs2=0xFFFFFFFF, XLEN=32 -> busy for 4 cycles, in_ready=0 throughout, then alu_result=0xFFFFFFFD.
REQ-036 SHALL be tested with jump_reg: rs1=0x1001, imm=4, pc=0x100 -> pc_target=0x1004, alu_result=0x104, branch_taken=1.
REQ-037 SHALL be tested with branch SUB: rs1=rs2=9, pc=0x200, imm=-8 -> pc_target=0x1F8, branch_taken=1; with rs2=8 -> branch_taken=0, pc_target=0x204.
REQ-038 SHALL be tested with backpressure: out_ready=0 for 3 cycles after a result -> outputs stable and in_ready=0; out_ready=1 together with in_valid -> new operation accepted the same cycle.
REQ-039 SHALL be tested with flush in MUL cycle 2, and separately with rst_n pulsed low mid-MUL -> out_valid never rises, busy=0, and the next ADD completes with 1-cycle latency.
